// File: rtl/auth_pkg.sv
// Shared definitions for the authentication message sender: one-hot state
// encoding, setup-packet length and default header/payload sizes.
package auth_pkg;

  localparam int SETUP_BYTES   = 8;
  localparam int HDR_BYTES_DEF = 4;
  localparam int PLD_BYTES_DEF = 28;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    LOAD      = 6'b000010,
    SETUP     = 6'b000100,
    DATA      = 6'b001000,
    WAIT_RESP = 6'b010000,
    DONE      = 6'b100000
  } state_e;

endpackage

// File: rtl/auth_timeout_counter.sv
// Response timeout down-counter: loaded when the last byte leaves, counts
// down while running and reports expiry when it reaches zero.
module auth_timeout_counter #(
  parameter int TMO_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMO_W-1:0] load_val,
  input  logic             run,
  output logic             expired
);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/auth_msg_sender.sv
// Sends a USB-style setup packet followed by an authentication message, then
// waits for a response. Define AUTH_TIMEOUT_EN to bound the response wait.
module auth_msg_sender
  import auth_pkg::*;
#(
  parameter int HDR_BYTES = HDR_BYTES_DEF,
  parameter int PLD_BYTES = PLD_BYTES_DEF,
  parameter int TMO_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msg_valid,
  input  logic [8*HDR_BYTES-1:0] header,
  input  logic [8*PLD_BYTES-1:0] payload,
  input  logic [7:0]             bmRequestType,
  input  logic [7:0]             bRequest,
  input  logic [15:0]            wLength,
  input  logic [TMO_W-1:0]       current_timeout,
  input  logic                   tx_ready,
  input  logic                   resp_valid,
  output logic                   msg_ack,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   tx_last,
  output logic                   busy_err,
  output logic                   timeout_err
);

  localparam int          TOTAL      = HDR_BYTES + PLD_BYTES;
  localparam int          DW         = 8 * TOTAL;
  localparam int          SW         = 8 * SETUP_BYTES;
  localparam logic [15:0] TOTAL16    = 16'(TOTAL);
  localparam logic [7:0]  TOTAL8     = 8'(TOTAL);
  localparam logic [7:0]  SETUP_LAST = 8'(SETUP_BYTES - 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [SW-1:0]   setup_q, setup_d;
  logic [15:0]     wlen_q, wlen_d;
  logic [7:0]      nbytes_q, nbytes_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            busy_q;
  logic            load_tmr;
  logic            tmr_expired;
`ifdef AUTH_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      setup_q  <= '0;
      wlen_q   <= '0;
      nbytes_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
`ifdef AUTH_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      setup_q  <= setup_d;
      wlen_q   <= wlen_d;
      nbytes_q <= nbytes_d;
      cnt_q    <= cnt_d;
      busy_q   <= msg_valid && (state_q != IDLE);
`ifdef AUTH_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  // Both byte streams are shift registers: the outgoing byte is always the top one.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    setup_d  = setup_q;
    wlen_d   = wlen_q;
    nbytes_d = nbytes_q;
    cnt_d    = cnt_q;
`ifdef AUTH_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    load_tmr = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    msg_ack  = 1'b0;
    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          state_d = LOAD;
          data_d  = {header, payload};
          setup_d = {bmRequestType, bRequest, 32'h0, wLength[7:0], wLength[15:8]};
          wlen_d  = wLength;
`ifdef AUTH_TIMEOUT_EN
          tmo_d   = current_timeout;
`endif
        end
      end
      LOAD: begin
        nbytes_d = (wlen_q < TOTAL16) ? wlen_q[7:0] : TOTAL8;
        cnt_d    = 8'd0;
        state_d  = SETUP;
      end
      SETUP: begin
        tx_valid = 1'b1;
        tx_data  = setup_q[SW-1 -: 8];
        tx_last  = (cnt_q == SETUP_LAST) && (nbytes_q == 8'd0);
        if (tx_ready) begin
          if (cnt_q == SETUP_LAST) begin
            cnt_d = 8'd0;
            if (nbytes_q == 8'd0) begin
              state_d  = WAIT_RESP;
              load_tmr = 1'b1;
            end else begin
              state_d = DATA;
            end
          end else begin
            cnt_d   = cnt_q + 8'd1;
            setup_d = setup_q << 8;
          end
        end
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_q[DW-1 -: 8];
        tx_last  = (cnt_q == (nbytes_q - 8'd1));
        if (tx_ready) begin
          if (tx_last) begin
            state_d  = WAIT_RESP;
            load_tmr = 1'b1;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            data_d = data_q << 8;
          end
        end
      end
      WAIT_RESP: begin
        // A response arriving on the expiry cycle still counts.
        if (resp_valid) begin
          state_d = DONE;
        end else if (tmr_expired) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        msg_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_err = busy_q;

`ifdef AUTH_TIMEOUT_EN
  auth_timeout_counter #(
    .TMO_W(TMO_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (load_tmr),
    .load_val(tmo_q),
    .run     (state_q == WAIT_RESP),
    .expired (tmr_expired)
  );

  assign timeout_err = (state_q == WAIT_RESP) && tmr_expired && !resp_valid;
`else
  logic unused_tmo;
  assign unused_tmo  = ^{current_timeout, load_tmr};
  assign tmr_expired = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_auth_msg_sender.sv
// Directed-vector bench for auth_msg_sender; timeout scenarios are selected
// with AUTH_TIMEOUT_EN to match the build of the design.
module tb_auth_msg_sender;

  logic         clk = 1'b0;
  logic         reset;
  logic         msg_valid;
  logic [31:0]  header;
  logic [223:0] payload;
  logic [7:0]   bmRequestType;
  logic [7:0]   bRequest;
  logic [15:0]  wLength;
  logic [31:0]  current_timeout;
  logic         tx_ready;
  logic         resp_valid;
  logic         msg_ack;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_last;
  logic         busy_err;
  logic         timeout_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] got_b [64];
  logic       got_l [64];
  int         got_n, hold_bad, busy_cnt, busy_cyc, inj_cyc;
  logic [7:0] exp_b [64];
  int         exp_n;

  auth_msg_sender dut (
    .clk            (clk),
    .reset          (reset),
    .msg_valid      (msg_valid),
    .header         (header),
    .payload        (payload),
    .bmRequestType  (bmRequestType),
    .bRequest       (bRequest),
    .wLength        (wLength),
    .current_timeout(current_timeout),
    .tx_ready       (tx_ready),
    .resp_valid     (resp_valid),
    .msg_ack        (msg_ack),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_last        (tx_last),
    .busy_err       (busy_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic set_msg(input logic [7:0] bm, input logic [7:0] br, input logic [15:0] wl,
                         input logic [31:0] hdr, input logic [223:0] pld, input logic [31:0] tmo);
    bmRequestType   = bm;
    bRequest        = br;
    wLength         = wl;
    header          = hdr;
    payload         = pld;
    current_timeout = tmo;
  endtask

  task automatic send_msg();
    msg_valid = 1'b1;
    @(posedge clk); #1;
    msg_valid = 1'b0;
  endtask

  // Records accepted bytes until tx_last; optionally injects one msg_valid
  // pulse once inj_at bytes have gone out.
  task automatic collect(input bit toggle, input int inj_at, input int budget);
    bit         done = 1'b0;
    bit         have_stall = 1'b0;
    logic [7:0] stall_b = 8'h00;
    got_n = 0; hold_bad = 0; busy_cnt = 0; busy_cyc = -1; inj_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      got_b[i] = 8'hxx;
      got_l[i] = 1'bx;
    end
    tx_ready = 1'b1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (busy_err) begin
        busy_cnt++;
        if (busy_cyc < 0) busy_cyc = c;
      end
      if (tx_valid && tx_ready) begin
        if (have_stall && tx_data !== stall_b) hold_bad++;
        have_stall = 1'b0;
        if (got_n < 64) begin
          got_b[got_n] = tx_data;
          got_l[got_n] = tx_last;
        end
        got_n++;
        if (tx_last) done = 1'b1;
      end else if (tx_valid) begin
        if (have_stall && tx_data !== stall_b) hold_bad++;
        have_stall = 1'b1;
        stall_b    = tx_data;
      end
      @(posedge clk); #1;
      msg_valid = 1'b0;
      if (inj_at >= 0 && got_n == inj_at && inj_cyc < 0) begin
        msg_valid = 1'b1;
        inj_cyc   = c;
      end
      tx_ready = toggle ? ~tx_ready : 1'b1;
    end
    msg_valid = 1'b0;
    tx_ready  = 1'b1;
  endtask

  task automatic load_basic_exp();
    logic [7:0] e [12] = '{8'h41, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'h04, 8'h00, 8'h01, 8'h81, 8'h00, 8'h00};
    exp_n = 12;
    for (int i = 0; i < 12; i++) exp_b[i] = e[i];
  endtask

  task automatic test_reset();
    reset = 1'b1; msg_valid = 1'b0; tx_ready = 1'b1; resp_valid = 1'b0;
    set_msg(8'h00, 8'h00, 16'h0000, 32'h0, 224'h0, 32'd0);
    #12;
    n_vec++;
    if ({tx_valid, tx_last, msg_ack, busy_err, timeout_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 00000", {tx_valid, tx_last, msg_ack, busy_err, timeout_err});
    end
    n_vec++;
    if (tx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_tx_data got %h want 00", tx_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input bit toggle);
    set_msg(8'h41, 8'h01, 16'd4, 32'h0181_0000, {28{8'hA5}}, 32'd1000);
    load_basic_exp();
    send_msg();
    collect(toggle, -1, 200);
    n_vec++;
    if (got_n !== exp_n) begin
      n_bad++;
      $display("FAIL basic_count toggle=%0d got %0d want %0d", toggle, got_n, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_l[i] !== (i == exp_n - 1)) begin
        n_bad++;
        $display("FAIL basic_byte%0d toggle=%0d got %h/%b want %h/%b", i, toggle, got_b[i], got_l[i],
                 exp_b[i], (i == exp_n - 1));
      end
    end
    n_vec++;
    if (hold_bad !== 0) begin
      n_bad++;
      $display("FAIL basic_hold toggle=%0d got %0d changes want 0", toggle, hold_bad);
    end
    repeat (2) @(posedge clk); #1;
    resp_valid = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (msg_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ack got %b want 1", msg_ack);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (msg_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ack_pulse got %b want 0", msg_ack);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_len();
    logic [223:0] pld;
    logic [7:0]   s [8] = '{8'hC1, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0]   h [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 28; i++) pld[8*(27-i) +: 8] = 8'h50 + 8'(i);
    for (int i = 0; i < 8; i++)  exp_b[i] = s[i];
    for (int i = 0; i < 4; i++)  exp_b[8+i] = h[i];
    for (int i = 0; i < 28; i++) exp_b[12+i] = 8'h50 + 8'(i);
    exp_n = 40;
    set_msg(8'hC1, 8'h05, 16'hFFFF, 32'h1122_3344, pld, 32'd1000);
    send_msg();
    collect(1'b0, -1, 200);
    n_vec++;
    if (got_n !== exp_n) begin
      n_bad++;
      $display("FAIL full_count got %0d want %0d", got_n, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_l[i] !== (i == exp_n - 1)) begin
        n_bad++;
        $display("FAIL full_byte%0d got %h/%b want %h/%b", i, got_b[i], got_l[i], exp_b[i], (i == exp_n - 1));
      end
    end
    @(posedge clk); #1;
    resp_valid = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (msg_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL full_ack got %b want 1", msg_ack);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    logic [7:0] s [8] = '{8'h21, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) exp_b[i] = s[i];
    exp_n = 8;
    set_msg(8'h21, 8'h09, 16'd0, 32'hFFFF_FFFF, {28{8'h3C}}, 32'd1000);
    send_msg();
    collect(1'b1, -1, 100);
    n_vec++;
    if (got_n !== exp_n) begin
      n_bad++;
      $display("FAIL zero_count got %0d want %0d", got_n, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_l[i] !== (i == exp_n - 1)) begin
        n_bad++;
        $display("FAIL zero_byte%0d got %h/%b want %h/%b", i, got_b[i], got_l[i], exp_b[i], (i == exp_n - 1));
      end
    end
    @(negedge clk);
    n_vec++;
    if (tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_wait_txvalid got %b want 0", tx_valid);
    end
    @(posedge clk); #1;
    resp_valid = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (msg_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_ack got %b want 1", msg_ack);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy();
    set_msg(8'h41, 8'h01, 16'd4, 32'h0181_0000, {28{8'hA5}}, 32'd1000);
    load_basic_exp();
    send_msg();
    set_msg(8'h99, 8'h77, 16'd2, 32'hDEAD_BEEF, {28{8'h5A}}, 32'd1);
    collect(1'b0, 9, 200);
    n_vec++;
    if (got_n !== exp_n) begin
      n_bad++;
      $display("FAIL busy_count got %0d want %0d", got_n, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_l[i] !== (i == exp_n - 1)) begin
        n_bad++;
        $display("FAIL busy_byte%0d got %h/%b want %h/%b", i, got_b[i], got_l[i], exp_b[i], (i == exp_n - 1));
      end
    end
    n_vec++;
    if (busy_cnt !== 1) begin
      n_bad++;
      $display("FAIL busy_pulses got %0d want 1", busy_cnt);
    end
    n_vec++;
    if (busy_cyc !== inj_cyc + 2) begin
      n_bad++;
      $display("FAIL busy_timing got cycle %0d want %0d", busy_cyc, inj_cyc + 2);
    end
    set_msg(8'h41, 8'h01, 16'd4, 32'h0181_0000, {28{8'hA5}}, 32'd1000);
    @(posedge clk); #1;
    resp_valid = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (msg_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_ack got %b want 1", msg_ack);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    set_msg(8'h41, 8'h01, 16'd4, 32'h0181_0000, {28{8'hA5}}, 32'd1000);
    tx_ready = 1'b1;
    send_msg();
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      n_bad++;
      $display("FAIL midrst_pre got %b/%h want 1/01", tx_valid, tx_data);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({tx_valid, tx_last, msg_ack, busy_err, timeout_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL midrst_flags got %b want 00000", {tx_valid, tx_last, msg_ack, busy_err, timeout_err});
    end
    n_vec++;
    if (tx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst_tx_data got %h want 00", tx_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      resp_valid = (k == 3);
      @(negedge clk);
      if (tx_valid || msg_ack || timeout_err) stray++;
      @(posedge clk); #1;
    end
    resp_valid = 1'b0;
    n_vec++;
    if (stray !== 0) begin
      n_bad++;
      $display("FAIL midrst_idle got %0d active cycles want 0", stray);
    end
    load_basic_exp();
    send_msg();
    collect(1'b0, -1, 200);
    n_vec++;
    if (got_n !== exp_n || got_b[0] !== 8'h41 || got_b[11] !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst_restart got %0d bytes first %h want 12 bytes first 41", got_n, got_b[0]);
    end
    @(posedge clk); #1;
    resp_valid = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef AUTH_TIMEOUT_EN
  task automatic test_timeout();
    int pulses, pulse_k, acks, ack_k;
    // No response: expiry exactly 10 cycles after entering WAIT_RESP.
    set_msg(8'h21, 8'h09, 16'd0, 32'h0, 224'h0, 32'd10);
    send_msg();
    collect(1'b0, -1, 100);
    pulses = 0; pulse_k = -1; acks = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (timeout_err) begin pulses++; pulse_k = k; end
      if (msg_ack) acks++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (pulses !== 1 || pulse_k !== 10) begin
      n_bad++;
      $display("FAIL tmo10_pulse got %0d pulses at %0d want 1 at 10", pulses, pulse_k);
    end
    n_vec++;
    if (acks !== 0) begin
      n_bad++;
      $display("FAIL tmo10_noack got %0d want 0", acks);
    end
    // Response on the expiry cycle wins.
    send_msg();
    collect(1'b0, -1, 100);
    pulses = 0; acks = 0; ack_k = -1;
    for (int k = 0; k < 14; k++) begin
      resp_valid = (k == 10);
      @(negedge clk);
      if (timeout_err) pulses++;
      if (msg_ack) begin acks++; ack_k = k; end
      @(posedge clk); #1;
    end
    resp_valid = 1'b0;
    n_vec++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL tmo_race_err got %0d pulses want 0", pulses);
    end
    n_vec++;
    if (acks !== 1 || ack_k !== 11) begin
      n_bad++;
      $display("FAIL tmo_race_ack got %0d acks at %0d want 1 at 11", acks, ack_k);
    end
    // Zero timeout expires on the first waiting cycle.
    set_msg(8'h21, 8'h09, 16'd0, 32'h0, 224'h0, 32'd0);
    send_msg();
    collect(1'b0, -1, 100);
    pulses = 0; pulse_k = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (timeout_err) begin pulses++; pulse_k = k; end
      @(posedge clk); #1;
    end
    n_vec++;
    if (pulses !== 1 || pulse_k !== 0) begin
      n_bad++;
      $display("FAIL tmo0_pulse got %0d pulses at %0d want 1 at 0", pulses, pulse_k);
    end
  endtask
`else
  task automatic test_timeout();
    int errs = 0, acks = 0;
    set_msg(8'h21, 8'h09, 16'd0, 32'h0, 224'h0, 32'd3);
    send_msg();
    collect(1'b0, -1, 100);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (timeout_err) errs++;
      if (msg_ack) acks++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (errs !== 0 || acks !== 0) begin
      n_bad++;
      $display("FAIL notmo_wait got %0d errs %0d acks want 0 0", errs, acks);
    end
    resp_valid = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (msg_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL notmo_ack got %b want 1", msg_ack);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_full_len();
    test_zero_len();
    test_busy();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
